// File: rtl/dmem_pkg.sv
// Shared types and widths for the data-memory responder.
package dmem_pkg;

  localparam int DMEM_DATA_W     = 32;
  localparam int DMEM_BE_W       = 4;
  localparam int DMEM_WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_state_t;

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store request-response bus between the core's memory stage (master)
// and the data-memory responder (slave).
interface dmem_responder_if #(
  parameter int ADDR_W = 12
);
  import dmem_pkg::*;

  logic                   req_valid;
  logic                   req_write;
  logic [ADDR_W-1:0]      req_addr;
  logic [DMEM_DATA_W-1:0] req_wdata;
  logic [DMEM_BE_W-1:0]   req_be;
  logic                   req_ready;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [DMEM_DATA_W-1:0] rsp_rdata;
  logic                   rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_array.sv
// DEPTH x 32 word RAM with per-byte write enables and a registered read port.
// The read register holds its value until the next read enable.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 2048,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic                   re,
  input  logic [IDX_W-1:0]       addr,
  input  logic [DMEM_DATA_W-1:0] wdata,
  input  logic [DMEM_BE_W-1:0]   be,
  output logic [DMEM_DATA_W-1:0] rdata
);

  logic [DMEM_DATA_W-1:0] mem [DEPTH];

  // Byte-lane write and registered read on the same word address.
  // NOTE: the storage has no reset branch so it maps onto block RAM; contents are undefined until written.
  // NOTE: sequential state uses <= so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < DMEM_BE_W; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: accepts one word-addressed load/store,
// waits WAIT_CYCLES cycles, then commits and presents a response that is held
// until the core consumes it. Addresses >= DEPTH get an error response.
// Optional: define DMEM_ERRCOUNT_EN to add a saturating err_count output.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int DEPTH       = 2048,
  parameter int WAIT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  dmem_responder_if.slave  bus
`ifdef DMEM_ERRCOUNT_EN
  ,
  output logic [7:0]       err_count
`endif
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [DMEM_WAIT_CNT_W-1:0] CNT_LOAD =
    DMEM_WAIT_CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  dmem_state_t                state, nextState;
  logic [DMEM_WAIT_CNT_W-1:0] cnt;
  logic                       accept, commit;

  logic                       writeQ;
  logic [ADDR_W-1:0]          addrQ;
  logic [DMEM_DATA_W-1:0]     wdataQ;
  logic [DMEM_BE_W-1:0]       beQ;

  logic                       cmdWrite, cmdValid;
  logic [ADDR_W-1:0]          cmdAddr;
  logic [DMEM_DATA_W-1:0]     cmdWdata;
  logic [DMEM_BE_W-1:0]       cmdBe;

  logic                       rspValidQ, rspErrQ, rdataSel;
  logic [DMEM_DATA_W-1:0]     ramRdata;

  assign bus.req_ready = (state == IDLE) && !rst;
  assign accept        = bus.req_valid && bus.req_ready;

  // With zero wait states the commit happens on the accept edge, before the
  // capture registers are loaded, so the live request fields are used then.
  assign cmdWrite = (state == IDLE) ? bus.req_write : writeQ;
  assign cmdAddr  = (state == IDLE) ? bus.req_addr  : addrQ;
  assign cmdWdata = (state == IDLE) ? bus.req_wdata : wdataQ;
  assign cmdBe    = (state == IDLE) ? bus.req_be    : beQ;
  assign cmdValid = (32'(cmdAddr) < 32'(DEPTH));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  // Next-state logic; commit marks the single edge that enters RESP.
  // NOTE: every output of this block gets a default first so no path leaves it unassigned and infers a latch.
  always_comb begin
    nextState = state;
    commit    = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES == 0) begin
            nextState = RESP;
            commit    = 1'b1;
          end else begin
            nextState = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          nextState = RESP;
          commit    = 1'b1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // Request capture and wait-state counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      writeQ <= 1'b0;
      addrQ  <= '0;
      wdataQ <= '0;
      beQ    <= '0;
      cnt    <= '0;
    end else if (accept) begin
      writeQ <= bus.req_write;
      addrQ  <= bus.req_addr;
      wdataQ <= bus.req_wdata;
      beQ    <= bus.req_be;
      cnt    <= CNT_LOAD;
    end else if (state == WAIT && cnt != '0) begin
      cnt <= cnt - DMEM_WAIT_CNT_W'(1);
    end
  end

  // Response registers: set on commit, held through RESP, cleared on consume.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rspValidQ <= 1'b0;
      rspErrQ   <= 1'b0;
      rdataSel  <= 1'b0;
    end else if (commit) begin
      rspValidQ <= 1'b1;
      rspErrQ   <= !cmdValid;
      rdataSel  <= cmdValid && !cmdWrite;
    end else if (state == RESP && bus.rsp_ready) begin
      rspValidQ <= 1'b0;
      rspErrQ   <= 1'b0;
      rdataSel  <= 1'b0;
    end
  end

  dmem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (commit && cmdValid && cmdWrite),
    .re    (commit && cmdValid && !cmdWrite),
    .addr  (cmdAddr[IDX_W-1:0]),
    .wdata (cmdWdata),
    .be    (cmdBe),
    .rdata (ramRdata)
  );

  assign bus.rsp_valid = rspValidQ;
  assign bus.rsp_err   = rspErrQ;
  assign bus.rsp_rdata = rdataSel ? ramRdata : '0;

`ifdef DMEM_ERRCOUNT_EN
  // Saturating count of commits that hit an invalid address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_count <= '0;
    else if (commit && !cmdValid && err_count != 8'hFF) err_count <= err_count + 8'd1;
  end
`endif

endmodule
